// File: rtl/mpi_credit_node.sv
// Credit-based ("yummy") point-to-point link endpoint: a credit-throttled TX packet generator
// and an RX FIFO that returns one credit per drained word.
module mpi_credit_node #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned CREDITS    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [31:0]       rank_i,
  input  logic [31:0]       dest_i,
  input  logic              yummy_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              rx_valid_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_ready_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              yummy_o,
  output logic              rx_overflow_o
);

  localparam int unsigned CntW   = $clog2(CREDITS + 1);
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW = $clog2(FIFO_DEPTH + 1);

  // TX state
  logic [CntW-1:0]   credit_q, credit_d;
  logic [31:0]       seq_q;
  logic              tx_valid_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              send;
  logic [63:0]       tx_word;

  // RX state
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CountW-1:0] count_q, count_d;
  logic              yummy_q, overflow_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              full, pop, push, overflow;

  // Only the low halves of the ranks go on the wire.
  logic unused_rank_bits;
  assign unused_rank_bits = ^{rank_i[31:16], dest_i[31:16]};

  always_comb begin
    send     = (credit_q != '0);
    credit_d = credit_q;
    tx_word  = {rank_i[15:0], dest_i[15:0], seq_q};
    if (send && !yummy_i) begin
      credit_d = credit_q - 1'b1;
    end else if (!send && yummy_i && (credit_q != CntW'(CREDITS))) begin
      credit_d = credit_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      credit_q   <= CntW'(CREDITS);
      seq_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      credit_q   <= credit_d;
      tx_valid_q <= send;
      if (send) begin
        tx_data_q <= DATA_W'(tx_word);
        seq_q     <= seq_q + 32'd1;
      end
    end
  end

  // A full FIFO may still accept a word when the head drains on the same edge.
  always_comb begin
    full     = (count_q == CountW'(FIFO_DEPTH));
    pop      = (count_q != '0) && rx_ready_i;
    push     = rx_valid_i && (!full || pop);
    overflow = rx_valid_i && full && !pop;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      yummy_q    <= 1'b0;
      rx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      yummy_q <= pop;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rx_data_q <= mem_q[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + 1'b1;
      end
      if (overflow) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rx_data_i;
    end
  end

  assign tx_valid_o    = tx_valid_q;
  assign tx_data_o     = tx_data_q;
  assign yummy_o       = yummy_q;
  assign rx_data_o     = rx_data_q;
  assign rx_overflow_o = overflow_q;

endmodule

// File: tb/tb_mpi_credit_node.sv
// Directed self-checking bench for mpi_credit_node: TX credit throttling, RX FIFO drain,
// overflow, reset mid-traffic and a loopback run.
module tb_mpi_credit_node;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [31:0] rank_i, dest_i;
  logic        yummy_i, tx_valid_o, rx_valid_i, rx_ready_i, yummy_o, rx_overflow_o;
  logic [63:0] tx_data_o, rx_data_i, rx_data_o;

  logic        lb;
  logic        yummy_drv, rx_valid_drv;
  logic [63:0] rx_data_drv;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  assign yummy_i    = lb ? yummy_o    : yummy_drv;
  assign rx_valid_i = lb ? tx_valid_o : rx_valid_drv;
  assign rx_data_i  = lb ? tx_data_o  : rx_data_drv;

  mpi_credit_node #(
    .DATA_W    (64),
    .CREDITS   (4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .rank_i       (rank_i),
    .dest_i       (dest_i),
    .yummy_i      (yummy_i),
    .tx_data_o    (tx_data_o),
    .tx_valid_o   (tx_valid_o),
    .rx_valid_i   (rx_valid_i),
    .rx_data_i    (rx_data_i),
    .rx_ready_i   (rx_ready_i),
    .rx_data_o    (rx_data_o),
    .yummy_o      (yummy_o),
    .rx_overflow_o(rx_overflow_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  function automatic logic [63:0] pkt(input logic [31:0] seq);
    return {16'h0000, 16'h0001, seq};
  endfunction

  logic [63:0] words [5];
  int          nyum;
  logic [31:0] exp_seq;

  initial begin
    words[0] = 64'hAAAA_0000_0000_000A;
    words[1] = 64'hBBBB_0000_0000_000B;
    words[2] = 64'hCCCC_0000_0000_000C;
    words[3] = 64'hDDDD_0000_0000_000D;
    words[4] = 64'hEEEE_0000_0000_000E;

    lb = 1'b0; rstn_i = 1'b0; rank_i = 32'd0; dest_i = 32'd1;
    yummy_drv = 1'b0; rx_valid_drv = 1'b0; rx_data_drv = '0; rx_ready_i = 1'b0;
    step(2);
    check("rst_tx_valid", tx_valid_o, 0);
    check("rst_tx_data", tx_data_o, 0);
    check("rst_yummy", yummy_o, 0);
    check("rst_rx_data", rx_data_o, 0);
    check("rst_overflow", rx_overflow_o, 0);

    // 1: exactly four packets without credit return
    rstn_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("s1_valid", tx_valid_o, 1);
      check("s1_data", tx_data_o, pkt(32'(i)));
    end
    for (int i = 0; i < 6; i++) begin
      step();
      check("s1_idle", tx_valid_o, 0);
    end
    check("s1_data_hold", tx_data_o, pkt(32'd3));

    // 2: one yummy buys exactly one packet
    yummy_drv = 1'b1;
    step();
    check("s2_no_send_yet", tx_valid_o, 0);
    yummy_drv = 1'b0;
    step();
    check("s2_valid", tx_valid_o, 1);
    check("s2_data", tx_data_o, pkt(32'd4));
    step();
    check("s2_idle", tx_valid_o, 0);

    // 3: single word round trip
    rx_ready_i = 1'b1; rx_valid_drv = 1'b1; rx_data_drv = 64'hDEAD_BEEF_0000_0001;
    step();
    rx_valid_drv = 1'b0;
    check("s3_yummy_early", yummy_o, 0);
    step();
    check("s3_yummy", yummy_o, 1);
    check("s3_data", rx_data_o, 64'hDEAD_BEEF_0000_0001);
    check("s3_overflow", rx_overflow_o, 0);
    step();
    check("s3_yummy_off", yummy_o, 0);
    check("s3_data_hold", rx_data_o, 64'hDEAD_BEEF_0000_0001);

    // 4: five words into four entries, then drain
    rx_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rx_valid_drv = 1'b1; rx_data_drv = words[i];
      step();
      check("s4_overflow", rx_overflow_o, (i == 4) ? 64'd1 : 64'd0);
      check("s4_no_yummy", yummy_o, 0);
    end
    rx_valid_drv = 1'b0; rx_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("s4_yummy", yummy_o, 1);
      check("s4_data", rx_data_o, words[i]);
    end
    step();
    check("s4_drained", yummy_o, 0);
    check("s4_data_hold", rx_data_o, words[3]);
    check("s4_sticky", rx_overflow_o, 1);

    // full FIFO: push and pop on the same edge, nothing lost
    rx_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx_valid_drv = 1'b1; rx_data_drv = words[i];
      step();
    end
    rx_ready_i = 1'b1; rx_data_drv = words[4];
    step();
    rx_valid_drv = 1'b0;
    check("full_pp_yummy", yummy_o, 1);
    check("full_pp_data", rx_data_o, words[0]);
    for (int i = 1; i < 5; i++) begin
      step();
      check("full_pp_drain", rx_data_o, words[i]);
      check("full_pp_yummy2", yummy_o, 1);
    end
    step();
    check("full_pp_empty", yummy_o, 0);

    // 6: reset mid-traffic, credits and seq restart
    rx_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rx_valid_drv = 1'b1; rx_data_drv = words[i];
      step();
    end
    rx_valid_drv = 1'b0;
    check("s6_pre_overflow", rx_overflow_o, 1);
    yummy_drv = 1'b1;
    rstn_i = 1'b0;
    step();
    check("s6_rst_yummy", yummy_o, 0);
    check("s6_rst_overflow", rx_overflow_o, 0);
    check("s6_rst_tx_valid", tx_valid_o, 0);
    check("s6_rst_tx_data", tx_data_o, 0);
    check("s6_rst_rx_data", rx_data_o, 0);
    rstn_i = 1'b1; rx_ready_i = 1'b1;
    // yummy held high with a full credit pool: sends continue, pool stays at 4
    for (int i = 0; i < 7; i++) begin
      step();
      check("s6_sat_valid", tx_valid_o, 1);
      check("s6_sat_data", tx_data_o, pkt(32'(i)));
      check("s6_fifo_empty", yummy_o, 0);
    end
    yummy_drv = 1'b0;
    for (int i = 7; i < 11; i++) begin
      step();
      check("s6_tail_valid", tx_valid_o, 1);
      check("s6_tail_data", tx_data_o, pkt(32'(i)));
    end
    step();
    check("s6_tail_idle", tx_valid_o, 0);

    // 5: loopback
    rstn_i = 1'b0; lb = 1'b1;
    step();
    rstn_i = 1'b1;
    exp_seq = 32'd0; nyum = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (yummy_o) begin
        check("s5_seq", rx_data_o, pkt(exp_seq));
        exp_seq = exp_seq + 32'd1;
        nyum++;
      end
    end
    check("s5_overflow", rx_overflow_o, 0);
    check("s5_throughput", (nyum >= 990) ? 64'd1 : 64'd0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
